// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-access command sequencer.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WR_DATA,
    ST_RD_DATA,
    ST_DROP
  } state_e;

  localparam logic [7:0] CMD_WR  = 8'h2A;
  localparam logic [7:0] CMD_RD  = 8'h2B;
  localparam logic [7:0] TX_IDLE = 8'h00;

endpackage

// File: rtl/spi_reg_ctrl.sv
// Command sequencer behind spi_slave: turns each CS frame's RX byte stream
// (command, address, data...) into register-bank write/read bursts and
// supplies the TX byte for the next SPI byte slot.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  spi_cs_n_i,
  input  logic                  spi_byte_vld_i,
  input  logic [7:0]            spi_byte_data_i,
  output logic [7:0]            spi_byte_data_o,
  output logic                  reg_wr_en_o,
  output logic                  reg_rd_en_o,
  output logic [ADDR_WIDTH-1:0] reg_addr_o,
  output logic [7:0]            reg_wr_data_o,
  input  logic [7:0]            reg_rd_data_i,
  output logic                  cmd_err_o
);

  state_e                state_q,    state_d;
  logic                  is_rd_q,    is_rd_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]            wr_data_q,  wr_data_d;
  logic                  wr_en_q,    wr_en_d;
  logic                  rd_en_q,    rd_en_d;
  logic                  rd_pend_q,  rd_pend_d;
  logic                  cmd_err_q,  cmd_err_d;
  logic [7:0]            tx_q,       tx_d;

  // Next-state, address counter, strobe and TX-byte decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d    = state_q;
    is_rd_d    = is_rd_q;
    addr_d     = addr_q;
    reg_addr_d = reg_addr_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    cmd_err_d  = 1'b0;
    rd_pend_d  = rd_en_q;
    tx_d       = tx_q;

    // Read data is valid the cycle after the strobe; capture it then.
    if (rd_pend_q) tx_d = reg_rd_data_i;

    case (state_q)
      ST_IDLE: begin
        if (!spi_cs_n_i) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (spi_byte_vld_i) begin
          if (spi_byte_data_i == CMD_WR) begin
            is_rd_d = 1'b0;
            state_d = ST_ADDR;
          end else if (spi_byte_data_i == CMD_RD) begin
            is_rd_d = 1'b1;
            state_d = ST_ADDR;
          end else begin
            cmd_err_d = 1'b1;
            state_d   = ST_DROP;
          end
        end
      end
      ST_ADDR: begin
        if (spi_byte_vld_i) begin
          addr_d = ADDR_WIDTH'(spi_byte_data_i);
          if (is_rd_q) begin
            // First read is issued straight from the address byte so the
            // data is ready for the first data byte slot.
            rd_en_d    = 1'b1;
            reg_addr_d = ADDR_WIDTH'(spi_byte_data_i);
            state_d    = ST_RD_DATA;
          end else begin
            state_d = ST_WR_DATA;
          end
        end
      end
      ST_WR_DATA: begin
        if (spi_byte_vld_i) begin
          wr_en_d    = 1'b1;
          reg_addr_d = addr_q;
          wr_data_d  = spi_byte_data_i;
          addr_d     = addr_q + 1'b1;
        end
      end
      ST_RD_DATA: begin
        // The RX byte is a dummy; each one prefetches the next address.
        if (spi_byte_vld_i) begin
          rd_en_d    = 1'b1;
          reg_addr_d = addr_q + 1'b1;
          addr_d     = addr_q + 1'b1;
        end
      end
      ST_DROP: begin
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame end wins over the per-state transition, but the byte handled
    // above in this same cycle still produces its strobe.
    if (spi_cs_n_i) state_d = ST_IDLE;

    // TX byte is only meaningful while streaming read data.
    if (state_d != ST_RD_DATA) tx_d = TX_IDLE;
  end

  // State and registered outputs; synchronous reset clears everything,
  // including a pending read capture.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst_i) begin
      state_q    <= ST_IDLE;
      is_rd_q    <= 1'b0;
      addr_q     <= '0;
      reg_addr_q <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_pend_q  <= 1'b0;
      cmd_err_q  <= 1'b0;
      tx_q       <= TX_IDLE;
    end else begin
      state_q    <= state_d;
      is_rd_q    <= is_rd_d;
      addr_q     <= addr_d;
      reg_addr_q <= reg_addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      rd_pend_q  <= rd_pend_d;
      cmd_err_q  <= cmd_err_d;
      tx_q       <= tx_d;
    end
  end

  assign spi_byte_data_o = tx_q;
  assign reg_wr_en_o     = wr_en_q;
  assign reg_rd_en_o     = rd_en_q;
  assign reg_addr_o      = reg_addr_q;
  assign reg_wr_data_o   = wr_data_q;
  assign cmd_err_o       = cmd_err_q;

endmodule
